dijkstra_relax_engine: RTL and testbench
========================================

// Module: dijkstra_relax_engine
// PURPOSE
//  Initiator side of the priority-queue push/pop interface: runs lazy Dijkstra from src to target.
//  Pops the min-distance entry, marks it visited, walks its CSR adjacency, pushes improved neighbours.
//  Sits between the host start/done handshake, the dist/prev RAM, and the graph RAMs (offset + edge).
// PARAMETERS
//  NUM_VERTICES  256  vertex count; vertex ids 0..NUM_VERTICES-1, 16-bit fields
//  QUEUE_DEPTH   64   queue capacity; a push at pq_queue_length==QUEUE_DEPTH is an overflow
//  PQ_LATENCY    3    cycles from pq_op_en pulse until the queue accepts the next op and pop data is valid
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-low reset (asserted when 0)
//  start            in   1   1-cycle pulse; sampled only in IDLE
//  src, target      in   16  source / target vertex ids
//  busy, done       out  1   busy: run in progress; done: 1-cycle pulse at end of run
//  found, error     out  1   target reached / queue overflow; held until next start
//  path_dist        out  16  final dist[target]; 16'hFFFF if unreached
//  pq_opcode        out  1   1=push, 0=pop
//  pq_op_en         out  1   1-cycle request strobe
//  pq_vertex, pq_prev_vertex, pq_dist  out 16  push payload
//  pq_queue_length  in   16  current queue occupancy
//  pq_pop_vertex, pq_pop_prev, pq_pop_dist  in 16  popped entry
//  off_rd_addr      out  16  -> off_rd_data in 32 {start[31:16], count[15:0]}, 1-cycle sync read
//  edge_rd_addr     out  16  -> edge_rd_data in 32 {dst[31:16], weight[15:0]}, 1-cycle sync read
//  dist_rd_addr     out  16  -> dist_rd_data in 16, 1-cycle sync read
//  dist_wr_en       out  1   writes dist_wr_data(16) and prev_wr_data(16) at dist_wr_addr(16)
// BEHAVIOUR
//  Reset: all outputs 0 except path_dist=16'hFFFF; FSM=IDLE; visited bitmap cleared.
//  States: IDLE -> CLEAR -> SEED -> CHECK -> POP -> POP_WAIT -> VISIT -> OFF_RD -> EDGE_RD
//   -> DIST_RD -> RELAX -> [PUSH -> PUSH_WAIT] -> EDGE_RD ... -> DONE -> IDLE.
//  CLEAR: one vertex per cycle, dist=INF(16'hFFFF), prev=vertex, visited=0; NUM_VERTICES cycles.
//  SEED: write dist[src]=0, prev[src]=src; push {src,src,0}.
//  CHECK: pq_queue_length==0 -> DONE, found=0.
//  POP/PUSH: pq_op_en high exactly 1 cycle, then wait PQ_LATENCY cycles; never two ops in flight.
//  VISIT: popped vertex already visited -> CHECK (stale entry, discarded);
//   else set visited; if vertex==target -> DONE, found=1, path_dist=pq_pop_dist.
//  OFF_RD/EDGE_RD: iterate edges start..start+count-1; count==0 -> CHECK.
//  RELAX: new=pq_pop_dist+weight, 17-bit sum saturated to 16'hFFFF. Push only if dst not visited
//   and new<dist[dst] (strict); on push write dist[dst]=new, prev[dst]=popped vertex.
//   Equal distance: no write, no push. Saturated INF is never pushed.
//  Overflow: push required while pq_queue_length==QUEUE_DEPTH -> no pq_op_en, error=1, DONE.
//  DONE: done=1 for one cycle, busy=0 next cycle, found/error/path_dist held.
//  start while busy: ignored. src/target latched on start; changes mid-run are ignored.
//  Out-of-range dst (>=NUM_VERTICES): edge skipped, no RAM access.
//  Reset mid-run: immediate return to IDLE, pq_op_en=0, no further RAM writes; next start re-CLEARs.
// STRUCTURE
//  pathfinder_pkg: INF constant, PQ_POP/PQ_PUSH opcode constants, edge_t {dst,weight},
//   off_t {start,count}, engine state enum.
//  Sub-module visited_bitmap: NUM_VERTICES flops, comb read, single-bit set, bulk clear.
//  Rest in one FSM plus datapath (cur vertex/dist, edge ptr/end, latency counter).
// TESTING (bench contains a behavioural priority queue honouring PQ_LATENCY)
//  Graph 0->1 w4, 0->2 w1, 2->1 w2, 1->3 w5; src0 target3 -> found=1, path_dist=8,
//   prev[3]=1, prev[1]=2; stale {1,0,4} popped and discarded.
//  src=target=5 -> done after first pop, found=1, path_dist=0, no pushes after seed.
//  Target 7 unreachable -> queue drains, found=0, path_dist=16'hFFFF, error=0.
//  Edges 0->1 wFFF0, 1->2 w0020; target2 -> sum saturates, no push, found=0.
//  QUEUE_DEPTH=2, vertex 0 with 3 out-edges -> error=1, done pulse, only 2 pushes strobed.
//  Reset low during EDGE_RD, then start src0 target3 -> pq_op_en=0 during reset, rerun gives path_dist=8.

Source files
------------

// File: rtl/pathfinder_pkg.sv
// Shared types and constants for the lazy-Dijkstra relax engine.
package pathfinder_pkg;

  localparam logic [15:0] INF     = 16'hFFFF;
  localparam logic        PQ_POP  = 1'b0;
  localparam logic        PQ_PUSH = 1'b1;

  typedef struct packed {
    logic [15:0] dst;
    logic [15:0] weight;
  } edge_t;

  typedef struct packed {
    logic [15:0] start;
    logic [15:0] count;
  } off_t;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_SEED, S_CHECK, S_POP, S_POP_WAIT, S_VISIT,
    S_OFF_RD, S_EDGE_RD, S_DIST_RD, S_RELAX, S_PUSH, S_PUSH_WAIT, S_DONE
  } state_e;

  // Candidate distance; a carry out of bit 15 clamps to INF.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? INF : s[15:0];
  endfunction

endpackage

// File: rtl/visited_bitmap.sv
// One flop per vertex: combinational read, single-bit set, bulk clear.
module visited_bitmap #(
  parameter int N = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        set,
  input  logic [15:0] set_idx,
  input  logic [15:0] rd_idx,
  output logic        rd_bit
);
  localparam int          AW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] N16 = 16'(N);

  logic [N-1:0] bits;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     bits <= '0;
    else if (clr)                   bits <= '0;
    else if (set && set_idx < N16)  bits[set_idx[AW-1:0]] <= 1'b1;
  end

  // Out-of-range ids read as unvisited; callers never act on them.
  assign rd_bit = (rd_idx < N16) ? bits[rd_idx[AW-1:0]] : 1'b0;

endmodule

// File: rtl/dijkstra_relax_engine.sv
// Lazy Dijkstra initiator: pops min entry, walks CSR adjacency, pushes improved neighbours.
module dijkstra_relax_engine
  import pathfinder_pkg::*;
#(
  parameter int NUM_VERTICES = 256,
  parameter int QUEUE_DEPTH  = 64,
  parameter int PQ_LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src,
  input  logic [15:0] target,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        error,
  output logic [15:0] path_dist,
  output logic        pq_opcode,
  output logic        pq_op_en,
  output logic [15:0] pq_vertex,
  output logic [15:0] pq_prev_vertex,
  output logic [15:0] pq_dist,
  input  logic [15:0] pq_queue_length,
  input  logic [15:0] pq_pop_vertex,
  input  logic [15:0] pq_pop_prev,
  input  logic [15:0] pq_pop_dist,
  output logic [15:0] off_rd_addr,
  input  logic [31:0] off_rd_data,
  output logic [15:0] edge_rd_addr,
  input  logic [31:0] edge_rd_data,
  output logic [15:0] dist_rd_addr,
  input  logic [15:0] dist_rd_data,
  output logic        dist_wr_en,
  output logic [15:0] dist_wr_addr,
  output logic [15:0] dist_wr_data,
  output logic [15:0] prev_wr_data
);
  localparam logic [15:0] NV16     = 16'(NUM_VERTICES);
  localparam logic [15:0] QD16     = 16'(QUEUE_DEPTH);
  localparam logic [7:0]  LAT_LAST = 8'(PQ_LATENCY - 1);

  state_e      state;
  logic [15:0] src_q, tgt_q, clr_idx, cur_v, cur_d, dist_q;
  logic [16:0] edge_ptr, edge_end, next_ptr;
  edge_t       edge_q, edge_w;
  off_t        off_w;
  logic [7:0]  lat_cnt;
  logic        phase, seeding;
  logic        vis_hit, vis_set, vis_clr;
  logic [15:0] vis_idx, new_dist;
  logic        unused_pop_prev;

  assign off_w    = off_t'(off_rd_data);
  assign edge_w   = edge_t'(edge_rd_data);
  assign next_ptr = edge_ptr + 17'd1;
  assign new_dist = sat_add(cur_d, edge_q.weight);
  assign vis_idx  = (state == S_VISIT) ? pq_pop_vertex : edge_q.dst;
  assign vis_set  = (state == S_VISIT) && !vis_hit;
  assign vis_clr  = (state == S_IDLE) && start;
  assign unused_pop_prev = ^pq_pop_prev;

  visited_bitmap #(.N(NUM_VERTICES)) u_visited (
    .clk     (clk),
    .reset   (reset),
    .clr     (vis_clr),
    .set     (vis_set),
    .set_idx (pq_pop_vertex),
    .rd_idx  (vis_idx),
    .rd_bit  (vis_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy <= 1'b0; done <= 1'b0; found <= 1'b0; error <= 1'b0; path_dist <= INF;
      pq_opcode <= PQ_POP; pq_op_en <= 1'b0;
      pq_vertex <= '0; pq_prev_vertex <= '0; pq_dist <= '0;
      off_rd_addr <= '0; edge_rd_addr <= '0; dist_rd_addr <= '0;
      dist_wr_en <= 1'b0; dist_wr_addr <= '0; dist_wr_data <= '0; prev_wr_data <= '0;
      src_q <= '0; tgt_q <= '0; clr_idx <= '0; cur_v <= '0; cur_d <= '0; dist_q <= '0;
      edge_ptr <= '0; edge_end <= '0; edge_q <= '0;
      lat_cnt <= '0; phase <= 1'b0; seeding <= 1'b0;
    end else begin
      pq_op_en   <= 1'b0;
      dist_wr_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          src_q <= src; tgt_q <= target;
          busy <= 1'b1; found <= 1'b0; error <= 1'b0; path_dist <= INF;
          clr_idx <= '0;
          state <= S_CLEAR;
        end
        S_CLEAR: begin
          dist_wr_en <= 1'b1; dist_wr_addr <= clr_idx;
          dist_wr_data <= INF; prev_wr_data <= clr_idx;
          clr_idx <= clr_idx + 16'd1;
          if (clr_idx == NV16 - 16'd1) state <= S_SEED;
        end
        S_SEED: begin
          pq_vertex <= src_q; pq_prev_vertex <= src_q; pq_dist <= '0;
          seeding <= 1'b1;
          state <= S_PUSH;
        end
        // The dist/prev write rides with the push strobe so an overflow leaves RAM untouched.
        S_PUSH: if (pq_queue_length >= QD16) begin
          error <= 1'b1;
          state <= S_DONE;
        end else begin
          pq_op_en <= 1'b1; pq_opcode <= PQ_PUSH;
          dist_wr_en <= 1'b1; dist_wr_addr <= pq_vertex;
          dist_wr_data <= pq_dist; prev_wr_data <= pq_prev_vertex;
          lat_cnt <= '0;
          state <= S_PUSH_WAIT;
        end
        S_PUSH_WAIT: if (lat_cnt != LAT_LAST) lat_cnt <= lat_cnt + 8'd1;
          else if (seeding) begin
            seeding <= 1'b0;
            state <= S_CHECK;
          end else if (next_ptr == edge_end) state <= S_CHECK;
          else begin
            edge_ptr <= next_ptr; edge_rd_addr <= next_ptr[15:0]; phase <= 1'b0;
            state <= S_EDGE_RD;
          end
        S_CHECK: state <= (pq_queue_length == '0) ? S_DONE : S_POP;
        S_POP: begin
          pq_op_en <= 1'b1; pq_opcode <= PQ_POP;
          lat_cnt <= '0;
          state <= S_POP_WAIT;
        end
        S_POP_WAIT: if (lat_cnt != LAT_LAST) lat_cnt <= lat_cnt + 8'd1;
          else state <= S_VISIT;
        S_VISIT: if (vis_hit) state <= S_CHECK;
          else begin
            cur_v <= pq_pop_vertex; cur_d <= pq_pop_dist;
            if (pq_pop_vertex == tgt_q) begin
              found <= 1'b1; path_dist <= pq_pop_dist;
              state <= S_DONE;
            end else begin
              off_rd_addr <= pq_pop_vertex; phase <= 1'b0;
              state <= S_OFF_RD;
            end
          end
        // Read states: phase 0 presents the address, phase 1 consumes the RAM data.
        S_OFF_RD: if (!phase) phase <= 1'b1;
          else begin
            phase <= 1'b0;
            edge_ptr <= {1'b0, off_w.start};
            edge_end <= {1'b0, off_w.start} + {1'b0, off_w.count};
            edge_rd_addr <= off_w.start;
            state <= (off_w.count == '0) ? S_CHECK : S_EDGE_RD;
          end
        S_EDGE_RD: if (!phase) phase <= 1'b1;
          else begin
            phase <= 1'b0;
            edge_q <= edge_w;
            if (edge_w.dst < NV16) begin
              dist_rd_addr <= edge_w.dst;
              state <= S_DIST_RD;
            end else if (next_ptr == edge_end) state <= S_CHECK;
            else begin
              edge_ptr <= next_ptr; edge_rd_addr <= next_ptr[15:0];
            end
          end
        S_DIST_RD: if (!phase) phase <= 1'b1;
          else begin
            phase <= 1'b0;
            dist_q <= dist_rd_data;
            state <= S_RELAX;
          end
        // Strict less-than against a stored value <= INF also keeps a saturated INF out of the queue.
        S_RELAX: if (!vis_hit && new_dist < dist_q) begin
            pq_vertex <= edge_q.dst; pq_prev_vertex <= cur_v; pq_dist <= new_dist;
            state <= S_PUSH;
          end else if (next_ptr == edge_end) state <= S_CHECK;
          else begin
            edge_ptr <= next_ptr; edge_rd_addr <= next_ptr[15:0]; phase <= 1'b0;
            state <= S_EDGE_RD;
          end
        S_DONE: begin
          done <= 1'b1; busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dijkstra_relax_engine.sv
// Directed bench: behavioural priority queue with latency, CSR graph RAMs, dist/prev RAM.
module tb_dijkstra_relax_engine;
  import pathfinder_pkg::*;

  localparam int          NV   = 256;
  localparam int          QD   = 2;
  localparam int          LAT  = 3;
  localparam logic [15:0] NV16 = 16'(NV);

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0] src = '0, target = '0;
  logic        busy, done, found, error, pq_opcode, pq_op_en, dist_wr_en;
  logic [15:0] path_dist, pq_vertex, pq_prev_vertex, pq_dist, pq_queue_length;
  logic [15:0] pq_pop_vertex, pq_pop_prev, pq_pop_dist;
  logic [15:0] off_rd_addr, edge_rd_addr, dist_rd_addr, dist_rd_data;
  logic [15:0] dist_wr_addr, dist_wr_data, prev_wr_data;
  logic [31:0] off_rd_data, edge_rd_data;

  logic [31:0] off_mem [NV];
  logic [31:0] edge_mem [64];
  logic [15:0] dist_mem [NV];
  logic [15:0] prev_mem [NV];

  int checks = 0, failures = 0;
  int n_push = 0, n_pop = 0, proto_err = 0, bad_addr = 0, qlen = 0, lat_cnt = 0;

  always #5 clk = ~clk;

  dijkstra_relax_engine #(.NUM_VERTICES(NV), .QUEUE_DEPTH(QD), .PQ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .target(target),
    .busy(busy), .done(done), .found(found), .error(error), .path_dist(path_dist),
    .pq_opcode(pq_opcode), .pq_op_en(pq_op_en), .pq_vertex(pq_vertex),
    .pq_prev_vertex(pq_prev_vertex), .pq_dist(pq_dist), .pq_queue_length(pq_queue_length),
    .pq_pop_vertex(pq_pop_vertex), .pq_pop_prev(pq_pop_prev), .pq_pop_dist(pq_pop_dist),
    .off_rd_addr(off_rd_addr), .off_rd_data(off_rd_data),
    .edge_rd_addr(edge_rd_addr), .edge_rd_data(edge_rd_data),
    .dist_rd_addr(dist_rd_addr), .dist_rd_data(dist_rd_data),
    .dist_wr_en(dist_wr_en), .dist_wr_addr(dist_wr_addr),
    .dist_wr_data(dist_wr_data), .prev_wr_data(prev_wr_data)
  );

  // Min-dist queue; pop data shows up LAT cycles after the strobe, garbage before that.
  typedef struct { logic [15:0] v, p, d; } ent_t;
  ent_t q[$];
  ent_t pend;
  logic pend_pop = 1'b0;

  function automatic int min_idx();
    int m = 0;
    for (int i = 1; i < q.size(); i++) if (q[i].d < q[m].d) m = i;
    return m;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      qlen <= 0; lat_cnt <= 0; pend_pop <= 1'b0;
      pq_pop_vertex <= '0; pq_pop_prev <= '0; pq_pop_dist <= '0;
    end else if (pq_op_en) begin
      if (lat_cnt != 0) proto_err <= proto_err + 1;
      lat_cnt <= LAT - 1;
      if (pq_opcode == PQ_PUSH) begin
        q.push_back('{pq_vertex, pq_prev_vertex, pq_dist});
        qlen <= qlen + 1; n_push <= n_push + 1;
      end else if (q.size() != 0) begin
        pend <= q[min_idx()];
        q.delete(min_idx());
        pend_pop <= 1'b1; qlen <= qlen - 1; n_pop <= n_pop + 1;
        pq_pop_vertex <= 16'hBEEF; pq_pop_prev <= 16'hBEEF; pq_pop_dist <= 16'h0000;
      end else proto_err <= proto_err + 1;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && pend_pop) begin
        pq_pop_vertex <= pend.v; pq_pop_prev <= pend.p; pq_pop_dist <= pend.d;
        pend_pop <= 1'b0;
      end
    end
  end
  assign pq_queue_length = 16'(qlen);

  always @(posedge clk) begin
    off_rd_data  <= off_mem[off_rd_addr[7:0]];
    edge_rd_data <= edge_mem[edge_rd_addr[5:0]];
    dist_rd_data <= dist_mem[dist_rd_addr[7:0]];
    if (dist_wr_en) begin
      if (dist_wr_addr < NV16) begin
        dist_mem[dist_wr_addr[7:0]] <= dist_wr_data;
        prev_mem[dist_wr_addr[7:0]] <= prev_wr_data;
      end else bad_addr <= bad_addr + 1;
    end
    if (busy && dist_rd_addr >= NV16) bad_addr <= bad_addr + 1;
  end

  task automatic clear_graph();
    for (int i = 0; i < NV; i++) off_mem[i] = 32'h0;
    for (int i = 0; i < 64; i++) edge_mem[i] = 32'h0;
  endtask

  // 0->1 w4, 0->2 w1, 2->1 w2, 1->3 w5
  task automatic load_graph1();
    clear_graph();
    off_mem[0] = {16'd0, 16'd2}; off_mem[1] = {16'd2, 16'd1}; off_mem[2] = {16'd3, 16'd1};
    edge_mem[0] = {16'd1, 16'd4}; edge_mem[1] = {16'd2, 16'd1};
    edge_mem[2] = {16'd3, 16'd5}; edge_mem[3] = {16'd1, 16'd2};
  endtask

  task automatic start_run(input logic [15:0] s, input logic [15:0] t);
    @(negedge clk); src = s; target = t; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, found, error, pq_op_en, dist_wr_en} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, found, error, pq_op_en, dist_wr_en});
    end
    checks++;
    if (path_dist !== 16'hFFFF) begin failures++; $display("FAIL reset_path_dist got=%h exp=ffff", path_dist); end
    reset = 1'b1;
  endtask

  task automatic test_shortest();
    bit ok; int p0, o0;
    load_graph1(); p0 = n_push; o0 = n_pop;
    start_run(16'd0, 16'd3);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL shortest_busy got=%b exp=1", busy); end
    repeat (50) @(negedge clk);
    src = 16'd1; target = 16'd2; start = 1'b1;   // must be ignored mid-run
    @(negedge clk); start = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL shortest_timeout got=no_done exp=done"); end
    checks++;
    if ({found, error, busy} !== 3'b100) begin failures++; $display("FAIL shortest_flags got=%b exp=100", {found, error, busy}); end
    checks++;
    if (path_dist !== 16'd8) begin failures++; $display("FAIL shortest_path_dist got=%0d exp=8", path_dist); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL shortest_done_width got=%b exp=0", done); end
    checks++;
    if ({prev_mem[3], prev_mem[1]} !== {16'd1, 16'd2}) begin
      failures++; $display("FAIL shortest_prev got=%0d,%0d exp=1,2", prev_mem[3], prev_mem[1]);
    end
    checks++;
    if ({dist_mem[3], dist_mem[1], dist_mem[2]} !== {16'd8, 16'd3, 16'd1}) begin
      failures++; $display("FAIL shortest_dist_ram got=%0d,%0d,%0d exp=8,3,1", dist_mem[3], dist_mem[1], dist_mem[2]);
    end
    checks++;
    if (n_push - p0 != 5 || n_pop - o0 != 5) begin
      failures++; $display("FAIL shortest_ops got=%0d/%0d exp=5/5", n_push - p0, n_pop - o0);
    end
    checks++;
    if (found !== 1'b1 || path_dist !== 16'd8) begin failures++; $display("FAIL shortest_hold got=%b/%0d exp=1/8", found, path_dist); end
  endtask

  task automatic test_src_is_target();
    bit ok; int p0;
    clear_graph(); off_mem[5] = {16'd0, 16'd1}; edge_mem[0] = {16'd6, 16'd1};
    p0 = n_push;
    start_run(16'd5, 16'd5); wait_done(ok);
    checks++;
    if (!ok || found !== 1'b1 || path_dist !== 16'd0) begin
      failures++; $display("FAIL self_target got=ok%0d f%b d%0d exp=ok1 f1 d0", ok, found, path_dist);
    end
    checks++;
    if (n_push - p0 != 1) begin failures++; $display("FAIL self_pushes got=%0d exp=1", n_push - p0); end
  endtask

  task automatic test_unreachable();
    bit ok; int p0;
    load_graph1(); p0 = n_push;
    start_run(16'd0, 16'd7); wait_done(ok);
    checks++;
    if (!ok || {found, error} !== 2'b00) begin failures++; $display("FAIL unreach_flags got=ok%0d %b exp=ok1 00", ok, {found, error}); end
    checks++;
    if (path_dist !== 16'hFFFF) begin failures++; $display("FAIL unreach_path_dist got=%h exp=ffff", path_dist); end
    checks++;
    if (n_push - p0 != 5 || qlen != 0) begin failures++; $display("FAIL unreach_drain got=%0d/%0d exp=5/0", n_push - p0, qlen); end
  endtask

  task automatic test_saturate();
    bit ok; int p0, b0;
    clear_graph();
    off_mem[0] = {16'd0, 16'd2}; off_mem[1] = {16'd2, 16'd1};
    edge_mem[0] = {16'd300, 16'd1}; edge_mem[1] = {16'd1, 16'hFFF0}; edge_mem[2] = {16'd2, 16'h0020};
    p0 = n_push; b0 = bad_addr;
    start_run(16'd0, 16'd2); wait_done(ok);
    checks++;
    if (!ok || found !== 1'b0 || path_dist !== 16'hFFFF) begin
      failures++; $display("FAIL sat_result got=ok%0d f%b d%h exp=ok1 f0 dffff", ok, found, path_dist);
    end
    checks++;
    if (n_push - p0 != 2) begin failures++; $display("FAIL sat_pushes got=%0d exp=2", n_push - p0); end
    checks++;
    if (dist_mem[2] !== 16'hFFFF || dist_mem[1] !== 16'hFFF0) begin
      failures++; $display("FAIL sat_dist_ram got=%h,%h exp=ffff,fff0", dist_mem[2], dist_mem[1]);
    end
    checks++;
    if (bad_addr != b0) begin failures++; $display("FAIL out_of_range_access got=%0d exp=0", bad_addr - b0); end
  endtask

  task automatic test_overflow();
    bit ok; int p0;
    clear_graph();
    off_mem[0] = {16'd0, 16'd3};
    edge_mem[0] = {16'd1, 16'd1}; edge_mem[1] = {16'd2, 16'd2}; edge_mem[2] = {16'd3, 16'd3};
    p0 = n_push;
    start_run(16'd0, 16'd9); wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL overflow_done got=no_done exp=done"); end
    checks++;
    if ({error, found, busy} !== 3'b100) begin failures++; $display("FAIL overflow_flags got=%b exp=100", {error, found, busy}); end
    checks++;
    if (n_push - p0 != 3) begin failures++; $display("FAIL overflow_pushes got=%0d exp=3", n_push - p0); end
    checks++;
    if (dist_mem[3] !== 16'hFFFF) begin failures++; $display("FAIL overflow_no_write got=%h exp=ffff", dist_mem[3]); end
    @(negedge clk); reset = 1'b0;   // flush leftover queue entries
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    bit ok; int e;
    load_graph1();
    start_run(16'd0, 16'd3);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (dut.state == S_EDGE_RD) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL midreset_reach_edge got=no exp=yes"); end
    reset = 1'b0; e = 0;
    repeat (3) begin
      @(negedge clk);
      if (pq_op_en !== 1'b0 || dist_wr_en !== 1'b0 || busy !== 1'b0) e++;
    end
    checks++;
    if (e != 0) begin failures++; $display("FAIL midreset_quiet got=%0d exp=0", e); end
    reset = 1'b1;
    start_run(16'd0, 16'd3); wait_done(ok);
    checks++;
    if (!ok || found !== 1'b1 || path_dist !== 16'd8) begin
      failures++; $display("FAIL midreset_rerun got=ok%0d f%b d%0d exp=ok1 f1 d8", ok, found, path_dist);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_err != 0) begin failures++; $display("FAIL pq_protocol got=%0d exp=0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_shortest();
    test_src_is_target();
    test_unreachable();
    test_saturate();
    test_overflow();
    test_reset_mid_run();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
